// File: rtl/arm_psr_pkg.sv
// ============================================================================
// Module   : arm_psr_pkg
// Brief    : Mode encodings, vector offsets, PSR bit indices and enums shared
//            by the PSR / exception controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package arm_psr_pkg;

    localparam logic [4:0] c_mode_usr = 5'b10000;
    localparam logic [4:0] c_mode_fiq = 5'b10001;
    localparam logic [4:0] c_mode_irq = 5'b10010;
    localparam logic [4:0] c_mode_svc = 5'b10011;
    localparam logic [4:0] c_mode_abt = 5'b10111;
    localparam logic [4:0] c_mode_und = 5'b11011;
    localparam logic [4:0] c_mode_sys = 5'b11111;

    localparam logic [31:0] c_vec_und = 32'h0000_0004;
    localparam logic [31:0] c_vec_swi = 32'h0000_0008;
    localparam logic [31:0] c_vec_abt = 32'h0000_0010;
    localparam logic [31:0] c_vec_irq = 32'h0000_0018;
    localparam logic [31:0] c_vec_fiq = 32'h0000_001C;

    localparam int c_bit_n    = 31;
    localparam int c_bit_z    = 30;
    localparam int c_bit_c    = 29;
    localparam int c_bit_v    = 28;
    localparam int c_bit_i    = 7;
    localparam int c_bit_f    = 6;
    localparam int c_bit_t    = 5;
    localparam int c_bit_m_hi = 4;
    localparam int c_bit_m_lo = 0;

    typedef enum logic [2:0] {
        EXC_NONE = 3'd0,
        EXC_ABT  = 3'd1,
        EXC_FIQ  = 3'd2,
        EXC_IRQ  = 3'd3,
        EXC_UND  = 3'd4,
        EXC_SWI  = 3'd5
    } exc_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENTRY  = 2'd1,
        ST_RET_RD = 2'd2,
        ST_RET_WR = 2'd3
    } state_e;

    // USR and SYS share the unbanked view and have no SPSR.
    function automatic logic has_spsr(input logic [4:0] m);
        return (m == c_mode_fiq) || (m == c_mode_irq) || (m == c_mode_svc) ||
               (m == c_mode_abt) || (m == c_mode_und);
    endfunction

    function automatic logic [2:0] spsr_slot(input logic [4:0] m);
        case (m)
            c_mode_fiq: return 3'd0;
            c_mode_irq: return 3'd1;
            c_mode_svc: return 3'd2;
            c_mode_abt: return 3'd3;
            c_mode_und: return 3'd4;
            default:    return 3'd0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/arm_exc_prio.sv
// ============================================================================
// Module   : arm_exc_prio
// Brief    : Combinational exception priority encoder (ABT > FIQ > IRQ > UND
//            > SWI) honouring the I and F masks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arm_exc_prio
    import arm_psr_pkg::*;
(
    input  logic        i_irq,
    input  logic        i_fiq,
    input  logic        i_abt,
    input  logic        i_und,
    input  logic        i_swi,
    input  logic        i_i_mask,
    input  logic        i_f_mask,
    output logic        o_valid,
    output exc_kind_e   o_kind,
    output logic [4:0]  o_mode,
    output logic [31:0] o_offset
);

    always_comb begin
        o_valid  = 1'b1;
        o_kind   = EXC_NONE;
        o_mode   = c_mode_usr;
        o_offset = '0;
        if (i_abt) begin
            o_kind = EXC_ABT; o_mode = c_mode_abt; o_offset = c_vec_abt;
        end else if (i_fiq && !i_f_mask) begin
            o_kind = EXC_FIQ; o_mode = c_mode_fiq; o_offset = c_vec_fiq;
        end else if (i_irq && !i_i_mask) begin
            o_kind = EXC_IRQ; o_mode = c_mode_irq; o_offset = c_vec_irq;
        end else if (i_und) begin
            o_kind = EXC_UND; o_mode = c_mode_und; o_offset = c_vec_und;
        end else if (i_swi) begin
            o_kind = EXC_SWI; o_mode = c_mode_svc; o_offset = c_vec_swi;
        end else begin
            o_valid = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/arm_psr_exc_ctrl.sv
// ============================================================================
// Module   : arm_psr_exc_ctrl
// Brief    : Owns CPSR and the banked SPSRs; sequences exception entry and
//            exception return onto the register-file write/PC/mode ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arm_psr_exc_ctrl
    import arm_psr_pkg::*;
#(
    parameter logic [31:0] VEC_BASE   = 32'h0000_0000,
    parameter logic [4:0]  RESET_MODE = 5'b10011
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        Irq,
    input  logic        Fiq,
    input  logic        Abt_Req,
    input  logic        Und_Req,
    input  logic        Swi_Req,
    input  logic        Ret_Req,
    input  logic [31:0] Ret_Addr,
    input  logic        Write_CPSR,
    input  logic        Write_SPSR,
    input  logic [31:0] PSR_In,
    input  logic [31:0] Rd_Data,
    output logic [4:0]  M,
    output logic        Write_Reg,
    output logic [3:0]  W_Addr,
    output logic [31:0] W_Data,
    output logic        Write_PC,
    output logic [31:0] PC_New,
    output logic        Rd_En,
    output logic [3:0]  Rd_Addr,
    output logic [31:0] CPSR,
    output logic [31:0] SPSR,
    output logic        Busy,
    output logic        Exc_Ack,
    output logic        Ret_Err
);

    localparam logic [3:0] c_lr_addr = 4'd14;

    state_e      r_state;
    state_e      w_next_state;
    logic [31:0] r_cpsr;
    logic [31:0] r_spsr [0:4];
    exc_kind_e   r_kind;
    logic [4:0]  r_tgt_mode;
    logic [31:0] r_vec;
    logic [31:0] r_ret_addr;
    logic [31:0] r_lr;
    logic        r_ret_err;

    logic        w_exc_valid;
    exc_kind_e   w_exc_kind;
    logic [4:0]  w_exc_mode;
    logic [31:0] w_exc_off;
    logic [4:0]  w_cur_mode;
    logic        w_cur_unpriv;
    logic [31:0] w_cur_spsr;

    assign w_cur_mode   = r_cpsr[c_bit_m_hi:c_bit_m_lo];
    assign w_cur_unpriv = (w_cur_mode == c_mode_usr) || (w_cur_mode == c_mode_sys);
    assign w_cur_spsr   = has_spsr(w_cur_mode) ? r_spsr[spsr_slot(w_cur_mode)] : 32'h0;

    arm_exc_prio u_prio (
        .i_irq    (Irq),
        .i_fiq    (Fiq),
        .i_abt    (Abt_Req),
        .i_und    (Und_Req),
        .i_swi    (Swi_Req),
        .i_i_mask (r_cpsr[c_bit_i]),
        .i_f_mask (r_cpsr[c_bit_f]),
        .o_valid  (w_exc_valid),
        .o_kind   (w_exc_kind),
        .o_mode   (w_exc_mode),
        .o_offset (w_exc_off)
    );

    always_ff @(posedge clk) begin
        if (Rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        M         = w_cur_mode;
        Write_Reg = 1'b0;
        W_Addr    = '0;
        W_Data    = '0;
        Write_PC  = 1'b0;
        PC_New    = '0;
        Rd_En     = 1'b0;
        Rd_Addr   = '0;
        Exc_Ack   = 1'b0;
        Busy      = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                // A pending exception always wins over a simultaneous return.
                if (w_exc_valid)                  w_next_state = ST_ENTRY;
                else if (Ret_Req && !w_cur_unpriv) w_next_state = ST_RET_RD;
            end
            ST_ENTRY: begin
                M         = r_tgt_mode;
                Write_Reg = 1'b1;
                W_Addr    = c_lr_addr;
                W_Data    = r_ret_addr;
                Write_PC  = 1'b1;
                PC_New    = r_vec;
                Exc_Ack   = 1'b1;
                w_next_state = ST_IDLE;
            end
            ST_RET_RD: begin
                Rd_En   = 1'b1;
                Rd_Addr = c_lr_addr;
                w_next_state = ST_RET_WR;
            end
            ST_RET_WR: begin
                Write_PC = 1'b1;
                PC_New   = r_lr;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            r_cpsr     <= {24'h0, 1'b1, 1'b1, 1'b0, RESET_MODE};
            for (int k = 0; k < 5; k++) r_spsr[k] <= '0;
            r_kind     <= EXC_NONE;
            r_tgt_mode <= RESET_MODE;
            r_vec      <= '0;
            r_ret_addr <= '0;
            r_lr       <= '0;
            r_ret_err  <= 1'b0;
        end else begin
            r_ret_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (Write_CPSR) begin
                        if (w_cur_mode == c_mode_usr)
                            r_cpsr <= {PSR_In[31:28], r_cpsr[27:0]};
                        else
                            r_cpsr <= PSR_In;
                    end
                    if (Write_SPSR && has_spsr(w_cur_mode))
                        r_spsr[spsr_slot(w_cur_mode)] <= PSR_In;
                    if (w_exc_valid) begin
                        r_kind     <= w_exc_kind;
                        r_tgt_mode <= w_exc_mode;
                        r_vec      <= VEC_BASE + w_exc_off;
                        r_ret_addr <= Ret_Addr;
                    end else if (Ret_Req && w_cur_unpriv) begin
                        r_ret_err <= 1'b1;
                    end
                end
                ST_ENTRY: begin
                    // r_cpsr already carries any MSR accepted alongside the request.
                    r_spsr[spsr_slot(r_tgt_mode)]   <= r_cpsr;
                    r_cpsr[c_bit_m_hi:c_bit_m_lo]    <= r_tgt_mode;
                    r_cpsr[c_bit_i]                  <= 1'b1;
                    r_cpsr[c_bit_t]                  <= 1'b0;
                    if (r_kind == EXC_FIQ) r_cpsr[c_bit_f] <= 1'b1;
                end
                ST_RET_RD: r_lr   <= Rd_Data;
                ST_RET_WR: r_cpsr <= w_cur_spsr;
                default: ;
            endcase
        end
    end

    assign CPSR    = r_cpsr;
    assign SPSR    = w_cur_spsr;
    assign Ret_Err = r_ret_err;

endmodule

`default_nettype wire

// File: tb/tb_arm_psr_exc_ctrl.sv
// ============================================================================
// Module   : tb_arm_psr_exc_ctrl
// Brief    : Directed plus randomized transaction bench for arm_psr_exc_ctrl
//            against a transaction-level PSR/exception model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arm_psr_exc_ctrl;

    logic        clk = 1'b0;
    logic        Rst, Irq, Fiq, Abt_Req, Und_Req, Swi_Req, Ret_Req;
    logic [31:0] Ret_Addr, PSR_In, Rd_Data;
    logic        Write_CPSR, Write_SPSR;
    logic [4:0]  M;
    logic        Write_Reg, Write_PC, Rd_En, Busy, Exc_Ack, Ret_Err;
    logic [3:0]  W_Addr, Rd_Addr;
    logic [31:0] W_Data, PC_New, CPSR, SPSR;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_cpsr;
    logic [31:0] m_spsr [5];
    logic [4:0]  valid_modes [7] = '{5'h10, 5'h11, 5'h12, 5'h13, 5'h17, 5'h1B, 5'h1F};

    arm_psr_exc_ctrl dut (
        .clk(clk), .Rst(Rst), .Irq(Irq), .Fiq(Fiq), .Abt_Req(Abt_Req),
        .Und_Req(Und_Req), .Swi_Req(Swi_Req), .Ret_Req(Ret_Req),
        .Ret_Addr(Ret_Addr), .Write_CPSR(Write_CPSR), .Write_SPSR(Write_SPSR),
        .PSR_In(PSR_In), .Rd_Data(Rd_Data), .M(M), .Write_Reg(Write_Reg),
        .W_Addr(W_Addr), .W_Data(W_Data), .Write_PC(Write_PC), .PC_New(PC_New),
        .Rd_En(Rd_En), .Rd_Addr(Rd_Addr), .CPSR(CPSR), .SPSR(SPSR), .Busy(Busy),
        .Exc_Ack(Exc_Ack), .Ret_Err(Ret_Err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic int bank(input logic [4:0] m);
        case (m)
            5'h11: return 0;
            5'h12: return 1;
            5'h13: return 2;
            5'h17: return 3;
            5'h1B: return 4;
            default: return -1;
        endcase
    endfunction

    function automatic logic [31:0] model_spsr(input logic [4:0] m);
        int b = bank(m);
        return (b < 0) ? 32'h0 : m_spsr[b];
    endfunction

    function automatic void model_reset();
        m_cpsr = 32'h0000_00D3;
        for (int k = 0; k < 5; k++) m_spsr[k] = 32'h0;
    endfunction

    function automatic void model_msr_cpsr(input logic [31:0] v);
        if (m_cpsr[4:0] == 5'h10) m_cpsr[31:28] = v[31:28];
        else                      m_cpsr = v;
    endfunction

    task automatic do_reset;
        Rst = 1'b1;
        tick; tick;
        Rst = 1'b0;
        model_reset();
        chk("rst_cpsr", CPSR, m_cpsr);
        chk("rst_m", {27'h0, M}, 32'h13);
        chk("rst_wreg", {31'h0, Write_Reg}, 32'h0);
        chk("rst_wpc", {31'h0, Write_PC}, 32'h0);
        chk("rst_busy", {31'h0, Busy}, 32'h0);
        chk("rst_spsr", SPSR, 32'h0);
        chk("rst_ack_err_rden", {29'h0, Exc_Ack, Ret_Err, Rd_En}, 32'h0);
    endtask

    task automatic msr_cpsr(input logic [31:0] v);
        Write_CPSR = 1'b1; PSR_In = v;
        tick;
        Write_CPSR = 1'b0;
        model_msr_cpsr(v);
        chk("msr_cpsr", CPSR, m_cpsr);
        chk("msr_m", {27'h0, M}, {27'h0, m_cpsr[4:0]});
        chk("msr_spsr_view", SPSR, model_spsr(m_cpsr[4:0]));
    endtask

    task automatic msr_spsr(input logic [31:0] v);
        int b = bank(m_cpsr[4:0]);
        Write_SPSR = 1'b1; PSR_In = v;
        tick;
        Write_SPSR = 1'b0;
        if (b >= 0) m_spsr[b] = v;
        chk("msr_spsr", SPSR, model_spsr(m_cpsr[4:0]));
        chk("msr_spsr_cpsr", CPSR, m_cpsr);
    endtask

    // Exception request, optionally with an MSR to CPSR in the same cycle.
    task automatic exc_step(input bit a, input bit f, input bit i, input bit u, input bit s,
                            input logic [31:0] ra, input bit wr, input logic [31:0] wv,
                            input bit hold_irq);
        bit take = 1'b1;
        logic [4:0] tm = 5'h0;
        logic [31:0] vec = 32'h0;
        if (a)                      begin tm = 5'h17; vec = 32'h10; end
        else if (f && !m_cpsr[6])   begin tm = 5'h11; vec = 32'h1C; end
        else if (i && !m_cpsr[7])   begin tm = 5'h12; vec = 32'h18; end
        else if (u)                 begin tm = 5'h1B; vec = 32'h04; end
        else if (s)                 begin tm = 5'h13; vec = 32'h08; end
        else take = 1'b0;
        Abt_Req = a; Fiq = f; Irq = i; Und_Req = u; Swi_Req = s; Ret_Addr = ra;
        Write_CPSR = wr; PSR_In = wv;
        tick;
        Write_CPSR = 1'b0;
        if (wr) model_msr_cpsr(wv);
        if (!take) begin
            {Abt_Req, Fiq, Irq, Und_Req, Swi_Req} = '0;
            chk("noexc_busy", {31'h0, Busy}, 32'h0);
            chk("noexc_cpsr", CPSR, m_cpsr);
            return;
        end
        chk("entry_m", {27'h0, M}, {27'h0, tm});
        chk("entry_wreg", {27'h0, Write_Reg, W_Addr}, {27'h0, 1'b1, 4'd14});
        chk("entry_wdata", W_Data, ra);
        chk("entry_wpc", {31'h0, Write_PC}, 32'h1);
        chk("entry_pcnew", PC_New, vec);
        chk("entry_ack_busy", {30'h0, Exc_Ack, Busy}, 32'h3);
        {Abt_Req, Fiq, Irq, Und_Req, Swi_Req} = '0;
        if (hold_irq) Irq = i;
        tick;
        m_spsr[bank(tm)] = m_cpsr;
        m_cpsr[4:0] = tm;
        m_cpsr[7] = 1'b1;
        m_cpsr[5] = 1'b0;
        if (tm == 5'h11) m_cpsr[6] = 1'b1;
        chk("post_cpsr", CPSR, m_cpsr);
        chk("post_spsr", SPSR, model_spsr(tm));
        chk("post_quiet", {28'h0, Exc_Ack, Write_Reg, Write_PC, Busy}, 32'h0);
        if (hold_irq) begin
            repeat (3) begin
                tick;
                chk("held_irq_busy", {31'h0, Busy}, 32'h0);
            end
            Irq = 1'b0;
        end
    endtask

    task automatic ret_step(input logic [31:0] lr);
        logic [4:0] om = m_cpsr[4:0];
        Ret_Req = 1'b1;
        tick;
        Ret_Req = 1'b0;
        if (om == 5'h10 || om == 5'h1F) begin
            chk("reterr_pulse", {31'h0, Ret_Err}, 32'h1);
            chk("reterr_nowrite", {29'h0, Busy, Write_PC, Write_Reg}, 32'h0);
            tick;
            chk("reterr_clear", {31'h0, Ret_Err}, 32'h0);
            chk("reterr_cpsr", CPSR, m_cpsr);
            return;
        end
        chk("retrd_rd", {27'h0, Rd_En, Rd_Addr}, {27'h0, 1'b1, 4'd14});
        chk("retrd_busy_nowr", {30'h0, Busy, Write_PC}, 32'h2);
        Rd_Data = lr;
        tick;
        Rd_Data = $urandom;
        chk("retwr_wpc", {31'h0, Write_PC}, 32'h1);
        chk("retwr_pcnew", PC_New, lr);
        chk("retwr_m", {27'h0, M}, {27'h0, om});
        tick;
        m_cpsr = model_spsr(om);
        chk("ret_cpsr", CPSR, m_cpsr);
        chk("ret_m_busy", {26'h0, Busy, M}, {27'h0, m_cpsr[4:0]});
    endtask

    function automatic logic [31:0] rand_psr();
        logic [31:0] v = $urandom;
        v[4:0] = valid_modes[$urandom_range(0, 6)];
        return v;
    endfunction

    initial begin
        {Rst, Irq, Fiq, Abt_Req, Und_Req, Swi_Req, Ret_Req, Write_CPSR, Write_SPSR} = '0;
        Ret_Addr = '0; PSR_In = '0; Rd_Data = '0;
        model_reset();

        do_reset;
        msr_cpsr(32'h0000_0010);
        msr_cpsr(32'hF000_00D3);
        msr_cpsr(32'h0000_0000);
        exc_step(0, 0, 1, 0, 0, 32'h104, 0, 32'h0, 0);
        chk("irq_entry_cpsr", CPSR, 32'h0000_0092);
        chk("irq_entry_spsr", SPSR, 32'h0000_0010);
        ret_step(32'h104);
        chk("ret_usr_cpsr", CPSR, 32'h0000_0010);
        exc_step(0, 1, 1, 0, 0, 32'h200, 0, 32'h0, 1);
        chk("fiq_entry_cpsr", CPSR, 32'h0000_00D1);
        ret_step(32'h200);
        ret_step(32'h300);

        // Reset while ENTRY is on the bus.
        Irq = 1'b1; Ret_Addr = 32'h104;
        tick;
        chk("abort_ack", {31'h0, Exc_Ack}, 32'h1);
        Irq = 1'b0; Rst = 1'b1;
        tick;
        Rst = 1'b0;
        model_reset();
        chk("abort_outs", {26'h0, Write_Reg, Write_PC, Rd_En, Exc_Ack, Busy, Ret_Err}, 32'h0);
        chk("abort_cpsr", CPSR, 32'h0000_00D3);
        msr_cpsr(32'h0000_0092);
        chk("abort_spsr_irq", SPSR, 32'h0);

        msr_cpsr(32'h0000_001F);
        exc_step(0, 0, 0, 0, 1, 32'h400, 1, 32'hA000_001F, 0);
        chk("msr_then_swi_spsr", SPSR, 32'hA000_001F);
        chk("msr_then_swi_cpsr", CPSR, 32'hA000_0093);
        ret_step(32'h404);

        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 3))
                0: msr_cpsr(rand_psr());
                1: msr_spsr(rand_psr());
                2: exc_step($urandom_range(0, 5) == 0, 1'($urandom), 1'($urandom),
                            1'($urandom), 1'($urandom), $urandom, 1'($urandom_range(0, 3) == 0),
                            rand_psr(), 1'($urandom));
                default: ret_step($urandom);
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish, observed running, expected done");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
